// File: rtl/bank_queue_pkg.sv
// Shared types and elaboration helpers for the bank queue monitor.
package bank_queue_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} wait_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Numerator width for SVC_TIME*(Pcount+Tcount-1).
    function automatic int num_width(input int n, input int svc);
        return n + 1 + clog2(svc + 1);
    endfunction

endpackage

// File: rtl/bank_queue_mc_div.sv
// Serial restoring divider for the wait estimate: one quotient bit per cycle,
// quotient saturated to W_W bits.
module bank_wait_div
    import bank_queue_pkg::*;
#(
    parameter int NUM_W = 7,
    parameter int DEN_W = 2,
    parameter int W_W   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [W_W-1:0]   quo
);

    localparam int CNT_W = clog2(NUM_W + 1);
    localparam int EXT_W = (NUM_W > W_W) ? NUM_W : W_W;

    logic [CNT_W-1:0] cnt;
    logic [DEN_W-1:0] rem_p1;
    logic [NUM_W-1:0] quo_p1;
    logic [DEN_W:0]   shl;
    logic             fit;

    function automatic logic [W_W-1:0] sat_quo(input logic [NUM_W-1:0] q);
        logic [EXT_W-1:0] qx;
        qx = EXT_W'(q);
        if (qx > EXT_W'({W_W{1'b1}})) return '1;
        return W_W'(qx);
    endfunction

    assign shl  = {rem_p1, quo_p1[NUM_W-1]};
    assign fit  = (shl >= {1'b0, den});
    assign done = busy && (cnt == CNT_W'(NUM_W - 1));
    assign quo  = sat_quo(quo_p1);

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

    // Stage p1: partial remainder and quotient shift register
    always_ff @(posedge clock) begin
        if (start) begin
            rem_p1 <= '0;
            quo_p1 <= num;
        end else if (busy) begin
            rem_p1 <= fit ? DEN_W'(shl - {1'b0, den}) : shl[DEN_W-1:0];
            quo_p1 <= {quo_p1[NUM_W-2:0], fit};
        end
    end

endmodule

// File: rtl/bank_queue_mc.sv
// Bank queue monitor: photocell counter with flags and a serial wait estimate.
// Optional photocell debounce filter enabled by defining BANK_QUEUE_DEBOUNCE_EN.
module bank_queue_mc
    import bank_queue_pkg::*;
#(
    parameter int N          = 4,
    parameter int T_W        = 2,
    parameter int SVC_TIME   = 3,
    parameter int W_W        = 6,
    parameter int DEB_CYCLES = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           phcOne,
    input  logic           phcTwo,
    input  logic [T_W-1:0] Tcount,
    output logic [N-1:0]   Pcount,
    output logic [W_W-1:0] Pwait,
    output logic           pwaitValid,
    output logic           emptyFlag,
    output logic           fullFlag,
    output logic           errFlag
);

    localparam int NUM_W = num_width(N, SVC_TIME);

    // Bit 0 is the entry cell, bit 1 the exit cell.
    logic [1:0] sync_p0, sync_p1, lvl, prev_p2, evt_p3;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
            prev_p2 <= 2'b11;
            evt_p3  <= 2'b00;
        end else begin
            sync_p0 <= {phcTwo, phcOne};
            sync_p1 <= sync_p0;
            prev_p2 <= lvl;
            evt_p3  <= prev_p2 & ~lvl;
        end
    end

`ifdef BANK_QUEUE_DEBOUNCE_EN
    localparam int DCW = clog2(DEB_CYCLES + 1);
    logic [1:0]     filt;
    logic [DCW-1:0] dcnt [2];

    always_ff @(posedge clock) begin
        if (reset) begin
            filt    <= 2'b11;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] != filt[i]) begin
                    if (dcnt[i] == DCW'(DEB_CYCLES - 1)) begin
                        filt[i] <= sync_p1[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync_p1;
`endif

    assign emptyFlag = (Pcount == '0);
    assign fullFlag  = &Pcount;

    // Simultaneous entry and exit cancel, even at the limits.
    always_ff @(posedge clock) begin
        if (reset) begin
            Pcount  <= '0;
            errFlag <= 1'b0;
        end else begin
            case (evt_p3)
                2'b01: if (fullFlag)  errFlag <= 1'b1; else Pcount <= Pcount + 1'b1;
                2'b10: if (emptyFlag) errFlag <= 1'b1; else Pcount <= Pcount - 1'b1;
                default: ;
            endcase
        end
    end

    wait_state_t      state;
    logic [N-1:0]     cap_p;
    logic [T_W-1:0]   cap_t;
    logic             sp_zero, sp_max, same_ops;
    logic [N:0]       opsum;
    logic [NUM_W-1:0] num;
    logic             div_busy, div_done;
    logic [W_W-1:0]   div_q;

    assign same_ops = (Pcount == cap_p) && (Tcount == cap_t);
    assign opsum    = {1'b0, Pcount} + {{(N + 1 - T_W){1'b0}}, Tcount} - (N + 1)'(1);
    assign num      = NUM_W'(opsum) * NUM_W'(SVC_TIME);

    bank_wait_div #(.NUM_W(NUM_W), .DEN_W(T_W), .W_W(W_W)) u_div (
        .clock (clock),
        .reset (reset),
        .start (state == LOAD),
        .num   (num),
        .den   (cap_t),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cap_p      <= '0;
            cap_t      <= Tcount;
            sp_zero    <= 1'b1;
            sp_max     <= 1'b0;
            Pwait      <= '0;
            pwaitValid <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (!same_ops) begin
                    state      <= LOAD;
                    pwaitValid <= 1'b0;
                end
                LOAD: begin
                    cap_p   <= Pcount;
                    cap_t   <= Tcount;
                    sp_zero <= (Pcount == '0);
                    sp_max  <= (Tcount == '0);
                    state   <= DIV;
                end
                DIV: if (div_done || !div_busy) state <= DONE;
                DONE: begin
                    // A stale quotient is dropped and the pass restarts.
                    if (same_ops) begin
                        Pwait      <= sp_zero ? '0 : (sp_max ? '1 : div_q);
                        pwaitValid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
            endcase
        end
    end

endmodule
